sync_gray_ptr_monitor: RTL and testbench
========================================

// Module: sync_gray_ptr_monitor
// PURPOSE
//  Parametrised successor to the FIFO pointer synchroniser. It brings a Gray-coded FIFO pointer
//  from a foreign clock domain into clk_i through a configurable N-flop chain.
//  It then converts the pointer to binary and reports the per-sample advance.
//  It flags Gray-code violations (>1 bit changed between consecutive synchronised samples).
//  It sits in the write or read domain of the async FIFO and feeds full/empty and fill-level logic.
// PARAMETERS
//  ADDR_SIZE    8  FIFO address bits; pointers are ADDR_SIZE+1 bits (extra wrap bit)
//  SYNC_STAGES  2  synchroniser flops in chain; legal >=2
//  CHECK_GRAY   1  1: Gray-violation detection enabled; 0: gray_err_o tied 0, err_cnt_o held 0
//  ERR_CNT_W    8  width of saturating violation counter
// PORTS
//  clk_i          in   1            destination-domain clock, all logic on rising edge
//  rst_i          in   1            synchronous reset, active high
//  ptr_gray_i     in   ADDR_SIZE+1  Gray pointer from foreign domain (asynchronous to clk_i)
//  ptr_gray_o     out  ADDR_SIZE+1  synchronised Gray pointer (last chain stage)
//  ptr_bin_o      out  ADDR_SIZE+1  binary equivalent of synchronised pointer, registered
//  ptr_changed_o  out  1            1-cycle pulse: synchronised pointer differs from previous sample
//  delta_o        out  ADDR_SIZE+1  advance since previous sample, binary, modulo 2^(ADDR_SIZE+1)
//  gray_err_o     out  1            1-cycle pulse: >1 bit differed between consecutive samples
//  err_cnt_o      out  ERR_CNT_W    count of gray_err_o pulses, saturating at all-ones
// BEHAVIOUR
//  - Reset (rst_i=1 at a rising edge): all chain flops, prev-sample register and all outputs <= 0.
//    Reset has priority over everything, including mid-stream.
//  - Chain: s[1] <= ptr_gray_i; s[k] <= s[k-1]; ptr_gray_o = s[SYNC_STAGES].
//    Latency from input to ptr_gray_o: SYNC_STAGES edges. No combinational path from ptr_gray_i to any output.
//  - prev <= s[SYNC_STAGES] every non-reset cycle.
//  - The following outputs are registered one edge after ptr_gray_o (latency SYNC_STAGES+1):
//      ptr_bin_o     <= gray2bin(s[SYNC_STAGES])  (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i])
//      delta_o       <= gray2bin(s[SYNC_STAGES]) - gray2bin(prev), truncated to ADDR_SIZE+1 bits
//      ptr_changed_o <= (s[SYNC_STAGES] != prev)
//      gray_err_o    <= CHECK_GRAY && popcount(s[SYNC_STAGES]^prev) > 1
//  - Wrap: the all-ones-binary to zero transition is a legal 1-bit Gray change.
//    It gives delta_o=1 and no error.
//  - On a violation, ptr_bin_o/delta_o still follow the sampled value (no hold).
//    gray_err_o pulses; err_cnt_o increments on the same edge as gray_err_o.
//    err_cnt_o stays at 2^ERR_CNT_W-1 once reached.
//  - Steady input: ptr_changed_o=0, delta_o=0, gray_err_o=0.
//  - First samples after reset are compared against prev=0. An input already non-zero at reset release
//    is reported as a jump; this is legal, and flags an error if >1 bit is set.
//  - Reset mid-operation: outputs return to 0 the edge after rst_i is sampled high.
//    The chain refills from the current ptr_gray_i after release.
//  - err_cnt_o clears only on reset.
// TESTING  (ADDR_SIZE=3, SYNC_STAGES=2 unless stated; 4-bit pointers)
//  1 Reset: hold rst_i 3 cycles with ptr_gray_i=4'b0110.
//    -> all outputs 0 during reset. After release: ptr_gray_o=0110 at edge 2, ptr_bin_o=0100,
//       delta_o=4, ptr_changed_o=1, gray_err_o=1, err_cnt_o=1 at edge 3.
//  2 Single step: 0000->0001 at edge 0.
//    -> ptr_gray_o=0001 after edge 2; ptr_bin_o=1, delta_o=1, ptr_changed_o=1 (one cycle), gray_err_o=0 after edge 3.
//  3 Count 0..15 and wrap, one Gray step per 4 cycles.
//    -> delta_o=1 on every change including 1000->0000; ptr_bin_o follows 0..15,0; err_cnt_o stays 0.
//  4 Violation: 0000->0011 (binary 2).
//    -> gray_err_o pulse, ptr_bin_o=2, delta_o=2, err_cnt_o=1. With CHECK_GRAY=0: no pulse, err_cnt_o=0.
//  5 Saturation: ERR_CNT_W=2; force 5 violations (alternate 0000/0011).
//    -> err_cnt_o 1,2,3,3,3.
//  6 SYNC_STAGES=3: step 0000->0001, then assert rst_i mid-chain at edge 2.
//    -> no output ever shows 0001 before reset; all 0 after edge 3.
//    After release the step appears on ptr_gray_o 3 edges later and on ptr_bin_o 4 edges later.

Source files
------------

// File: rtl/sync_gray_ptr_monitor.sv
// rtl/sync_gray_ptr_monitor.sv - Gray pointer synchroniser with binary conversion, advance and violation monitor
module sync_gray_ptr_monitor #(
    parameter int ADDR_SIZE   = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit CHECK_GRAY  = 1'b1,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE:0]   ptr_gray_i,
    output logic [ADDR_SIZE:0]   ptr_gray_o,
    output logic [ADDR_SIZE:0]   ptr_bin_o,
    output logic                 ptr_changed_o,
    output logic [ADDR_SIZE:0]   delta_o,
    output logic                 gray_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int PW = ADDR_SIZE + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]        sync_q [SYNC_STAGES];
    logic [PW-1:0]        prev_q;
    logic [PW-1:0]        bin_q, bin_d;
    logic [PW-1:0]        delta_q, delta_d;
    logic                 changed_q, changed_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        cur;
    logic [PW-1:0]        diff;

    assign cur = sync_q[SYNC_STAGES-1];

    always_comb begin
        diff      = cur ^ prev_q;
        bin_d     = gray2bin(cur);
        delta_d   = gray2bin(cur) - gray2bin(prev_q);
        changed_d = (diff != '0);
        // Clearing the lowest set bit leaves something only when two or more bits differ.
        err_d     = CHECK_GRAY && ((diff & (diff - 1'b1)) != '0);
        cnt_d     = cnt_q;
        if (err_d && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q    <= '0;
            bin_q     <= '0;
            delta_q   <= '0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q[0] <= ptr_gray_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q    <= cur;
            bin_q     <= bin_d;
            delta_q   <= delta_d;
            changed_q <= changed_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ptr_gray_o    = cur;
    assign ptr_bin_o     = bin_q;
    assign delta_o       = delta_q;
    assign ptr_changed_o = changed_q;
    assign gray_err_o    = err_q;
    assign err_cnt_o     = cnt_q;

endmodule

// File: tb/tb_sync_gray_ptr_monitor.sv
// tb/tb_sync_gray_ptr_monitor.sv - randomized model-checked bench for three configurations of sync_gray_ptr_monitor
module tb_sync_gray_ptr_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pin;

    logic [3:0] go [3];
    logic [3:0] bo [3];
    logic [3:0] dl [3];
    logic       ch [3];
    logic       ge [3];
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance 0: reference config; 1: checking disabled; 2: three stages, 2-bit counter
    sync_gray_ptr_monitor #(.ADDR_SIZE(3), .SYNC_STAGES(2), .CHECK_GRAY(1'b1), .ERR_CNT_W(8)) u0 (
        .clk_i(clk), .rst_i(rst), .ptr_gray_i(pin), .ptr_gray_o(go[0]), .ptr_bin_o(bo[0]),
        .ptr_changed_o(ch[0]), .delta_o(dl[0]), .gray_err_o(ge[0]), .err_cnt_o(ec0));
    sync_gray_ptr_monitor #(.ADDR_SIZE(3), .SYNC_STAGES(2), .CHECK_GRAY(1'b0), .ERR_CNT_W(8)) u1 (
        .clk_i(clk), .rst_i(rst), .ptr_gray_i(pin), .ptr_gray_o(go[1]), .ptr_bin_o(bo[1]),
        .ptr_changed_o(ch[1]), .delta_o(dl[1]), .gray_err_o(ge[1]), .err_cnt_o(ec1));
    sync_gray_ptr_monitor #(.ADDR_SIZE(3), .SYNC_STAGES(3), .CHECK_GRAY(1'b1), .ERR_CNT_W(2)) u2 (
        .clk_i(clk), .rst_i(rst), .ptr_gray_i(pin), .ptr_gray_o(go[2]), .ptr_bin_o(bo[2]),
        .ptr_changed_o(ch[2]), .delta_o(dl[2]), .gray_err_o(ge[2]), .err_cnt_o(ec2));

    always #5 clk = ~clk;

    int stages [3] = '{2, 2, 3};
    bit chkon  [3] = '{1'b1, 1'b0, 1'b1};
    int cmax   [3] = '{255, 255, 3};

    logic [3:0] m_pipe [3][3];
    logic [3:0] m_prev [3];
    logic [3:0] m_bin [3];
    logic [3:0] m_dl [3];
    bit         m_ch [3];
    bit         m_err [3];
    int         m_cnt [3];

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b = 4'd0;
        for (int i = 0; i < 4; i++) b = b ^ (g >> i);
        return b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ecv(input int i);
        return (i == 0) ? int'(ec0) : (i == 1) ? int'(ec1) : int'(ec2);
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) m_pipe[i][k] = 4'd0;
            m_prev[i] = 4'd0; m_bin[i] = 4'd0; m_dl[i] = 4'd0;
            m_ch[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
        end
    end

    // Reference: the value seen at the chain end is compared with the one seen a cycle earlier
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [3:0] g;
            if (rst) begin
                for (int k = 0; k < 3; k++) m_pipe[i][k] = 4'd0;
                m_prev[i] = 4'd0; m_bin[i] = 4'd0; m_dl[i] = 4'd0;
                m_ch[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
            end else begin
                g = m_pipe[i][stages[i]-1];
                m_bin[i] = g2b(g);
                m_dl[i]  = 4'((int'(g2b(g)) - int'(g2b(m_prev[i])) + 16) % 16);
                m_ch[i]  = (g != m_prev[i]);
                m_err[i] = chkon[i] && ($countones(g ^ m_prev[i]) > 1);
                if (m_err[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
                m_prev[i] = g;
                for (int k = 2; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
                m_pipe[i][0] = pin;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d_gray", i), go[i], m_pipe[i][stages[i]-1]);
            chk($sformatf("m%0d_bin", i), bo[i], m_bin[i]);
            chk($sformatf("m%0d_delta", i), dl[i], m_dl[i]);
            chk($sformatf("m%0d_chg", i), ch[i], m_ch[i]);
            chk($sformatf("m%0d_err", i), ge[i], m_err[i]);
            chk($sformatf("m%0d_cnt", i), ecv(i), m_cnt[i]);
        end
    end

    task automatic do_reset(input logic [3:0] v);
        #1 rst = 1'b1; pin = v;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [3:0] bcnt;
    int r;

    initial begin
        rst = 1'b1; pin = 4'b0110;
        repeat (3) @(negedge clk);
        chk("rst_gray", go[0], 0); chk("rst_bin", bo[0], 0); chk("rst_cnt", ec0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t1_gray", go[0], 6);
        @(negedge clk);
        chk("t1_bin", bo[0], 4); chk("t1_delta", dl[0], 4); chk("t1_chg", ch[0], 1);
        chk("t1_err", ge[0], 1); chk("t1_cnt", ec0, 1); chk("t1_nochk_err", ge[1], 0);
        @(negedge clk);
        chk("t1_chg_pulse", ch[0], 0); chk("t1_err_pulse", ge[0], 0); chk("t1_cnt_hold", ec0, 1);

        do_reset(4'b0000);
        repeat (2) @(negedge clk);
        #1 pin = 4'b0001;
        repeat (2) @(negedge clk);
        chk("t2_gray", go[0], 1); chk("t2_bin_early", bo[0], 0);
        @(negedge clk);
        chk("t2_bin", bo[0], 1); chk("t2_delta", dl[0], 1); chk("t2_chg", ch[0], 1); chk("t2_err", ge[0], 0);

        do_reset(4'b0000);
        #1 pin = 4'b0011;
        repeat (3) @(negedge clk);
        chk("t4_bin", bo[0], 2); chk("t4_delta", dl[0], 2); chk("t4_err", ge[0], 1); chk("t4_cnt", ec0, 1);
        chk("t4_nochk_err", ge[1], 0); chk("t4_nochk_cnt", ec1, 0);

        do_reset(4'b1000);
        repeat (4) @(negedge clk);
        chk("wrap_bin15", bo[0], 15); chk("wrap_cnt0", ec0, 0);
        #1 pin = 4'b0000;
        repeat (3) @(negedge clk);
        chk("wrap_delta", dl[0], 1); chk("wrap_bin0", bo[0], 0); chk("wrap_err", ge[0], 0);

        do_reset(4'b0000);
        for (int k = 1; k <= 5; k++) begin
            #1 pin = (k % 2 == 1) ? 4'b0011 : 4'b0000;
            repeat (5) @(negedge clk);
            chk($sformatf("sat_%0d", k), ec2, (k < 3) ? k : 3);
        end

        do_reset(4'b0000);
        #1 pin = 4'b0001;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_gray", go[2], 0); chk("t6_rst_bin", bo[2], 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_gray_early", go[2], 0);
        @(negedge clk);
        chk("t6_gray", go[2], 1); chk("t6_bin_early", bo[2], 0);
        @(negedge clk);
        chk("t6_bin", bo[2], 1);

        do_reset(4'b0000);
        bcnt = 4'd0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            #1;
            r = $urandom_range(0, 99);
            rst = (r < 2);
            if (r < 55)      bcnt = bcnt + 4'd1;
            else if (r < 65) bcnt = bcnt - 4'd1;
            else if (r < 92) bcnt = bcnt;
            else             bcnt = 4'($urandom_range(0, 15));
            pin = bcnt ^ (bcnt >> 1);
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
